// File: rtl/smu_dribble_ctl_if.sv
// DCU request/acknowledge channel between the SMU dribble controller and the DCU.
// The controller uses the master modport. The DCU, or the bench, uses the slave modport.
interface smu_dribble_ctl_if;
  logic        smu_req;
  logic        smu_we;
  logic [31:0] smu_addr;
  logic        dcu_ack;

  modport master (output smu_req, output smu_we, output smu_addr, input dcu_ack);
  modport slave  (input smu_req, input smu_we, input smu_addr, output dcu_ack);
endinterface

// File: rtl/smu_dribble_ctl.sv
// Stack-cache dribble controller: spills entries above hi_mark and fills them back below lo_mark.
// It issues one word request at a time and tracks SC_BOTTOM, the spilled-word count, hold and stats.
module smu_dribble_ctl #(
  parameter int unsigned SC_DEPTH = 64,
  parameter int unsigned HOLD_GAP = 2,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned NW      = $clog2(SC_DEPTH)
) (
  input  logic                pj_clk,
  input  logic                reset_l,
  smu_dribble_ctl_if.master   dcu,
  input  logic [NW-1:0]       num_entries,
  input  logic [NW-1:0]       hi_mark,
  input  logic [NW-1:0]       lo_mark,
  input  logic                dribble_en,
  input  logic                sc_bottom_wr,
  input  logic [31:0]         sc_bottom_in,
  input  logic                stat_clr,
  output logic [31:0]         sc_bottom,
  output logic                smu_spill_done,
  output logic                smu_fill_done,
  output logic                smu_hold,
  output logic [CNT_W-1:0]    mem_entries,
  output logic [CNT_W-1:0]    spill_cnt,
  output logic [CNT_W-1:0]    fill_cnt
);

  localparam int unsigned HOLD_LVL = SC_DEPTH - HOLD_GAP;

  typedef enum logic [1:0] {IDLE, SPILL, FILL, COOL} state_e;

  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        bottom_q, bottom_d;
  logic [CNT_W-1:0]   mem_q, mem_d;
  logic [CNT_W-1:0]   spill_cnt_q, spill_cnt_d;
  logic [CNT_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic               spill_done_q, spill_done_d;
  logic               fill_done_q, fill_done_d;
  logic               hold_q, hold_d;

  logic spill_go_c, fill_go_c;

  assign spill_go_c = dribble_en && (num_entries > hi_mark);
  assign fill_go_c  = dribble_en && (num_entries < lo_mark) && (mem_q != '0);

  // Next-state and register updates; stat_clr overrides any same-cycle increment.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    bottom_d     = bottom_q;
    mem_d        = mem_q;
    spill_done_d = 1'b0;
    fill_done_d  = 1'b0;
    spill_cnt_d  = stat_clr ? '0 : spill_cnt_q;
    fill_cnt_d   = stat_clr ? '0 : fill_cnt_q;
    hold_d       = (num_entries >= NW'(HOLD_LVL));

    case (state_q)
      IDLE: begin
        if (spill_go_c) begin
          state_d = SPILL;
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = bottom_q;
        end else if (fill_go_c) begin
          state_d = FILL;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = bottom_q + 32'd4;
        end
      end
      SPILL: begin
        if (dcu.dcu_ack) begin
          state_d      = COOL;
          req_d        = 1'b0;
          spill_done_d = 1'b1;
          bottom_d     = bottom_q - 32'd4;
          if (mem_q != '1) mem_d = mem_q + CNT_W'(1);
          if (!stat_clr && (spill_cnt_q != '1)) spill_cnt_d = spill_cnt_q + CNT_W'(1);
        end
      end
      FILL: begin
        if (dcu.dcu_ack) begin
          state_d     = COOL;
          req_d       = 1'b0;
          fill_done_d = 1'b1;
          bottom_d    = bottom_q + 32'd4;
          if (mem_q != '0) mem_d = mem_q - CNT_W'(1);
          if (!stat_clr && (fill_cnt_q != '1)) fill_cnt_d = fill_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A software write of SC_BOTTOM beats any pointer adjustment from an ack.
    if (sc_bottom_wr) begin
      bottom_d = sc_bottom_in & ~32'h3;
      mem_d    = '0;
    end
  end

  always_ff @(posedge pj_clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      bottom_q     <= '0;
      mem_q        <= '0;
      spill_cnt_q  <= '0;
      fill_cnt_q   <= '0;
      spill_done_q <= 1'b0;
      fill_done_q  <= 1'b0;
      hold_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      bottom_q     <= bottom_d;
      mem_q        <= mem_d;
      spill_cnt_q  <= spill_cnt_d;
      fill_cnt_q   <= fill_cnt_d;
      spill_done_q <= spill_done_d;
      fill_done_q  <= fill_done_d;
      hold_q       <= hold_d;
    end
  end

  assign dcu.smu_req     = req_q;
  assign dcu.smu_we      = we_q;
  assign dcu.smu_addr    = addr_q;
  assign sc_bottom       = bottom_q;
  assign smu_spill_done  = spill_done_q;
  assign smu_fill_done   = fill_done_q;
  assign smu_hold        = hold_q;
  assign mem_entries     = mem_q;
  assign spill_cnt       = spill_cnt_q;
  assign fill_cnt        = fill_cnt_q;

endmodule

// File: tb/tb_smu_dribble_ctl.sv
// Directed bench for smu_dribble_ctl. The main instance covers the request/ack sequences.
// A narrow-counter instance with a permanently asserted ack exercises saturation.
module tb_smu_dribble_ctl;

  logic        pj_clk = 1'b0;
  logic        reset_l;
  logic [5:0]  num_entries, hi_mark, lo_mark;
  logic        dribble_en, sc_bottom_wr, stat_clr;
  logic [31:0] sc_bottom_in;

  logic [31:0] sc_bottom, sc_bottom2;
  logic        spill_done, fill_done, hold, spill_done2, fill_done2, hold2;
  logic [15:0] mem_entries, spill_cnt, fill_cnt;
  logic [3:0]  mem_entries2, spill_cnt2, fill_cnt2;

  int errors = 0;
  int checks = 0;

  smu_dribble_ctl_if bus ();
  smu_dribble_ctl_if bus2 ();

  assign bus2.dcu_ack = 1'b1;

  always #5 pj_clk = ~pj_clk;

  smu_dribble_ctl dut (
    .pj_clk(pj_clk), .reset_l(reset_l), .dcu(bus),
    .num_entries(num_entries), .hi_mark(hi_mark), .lo_mark(lo_mark),
    .dribble_en(dribble_en), .sc_bottom_wr(sc_bottom_wr), .sc_bottom_in(sc_bottom_in),
    .stat_clr(stat_clr), .sc_bottom(sc_bottom), .smu_spill_done(spill_done),
    .smu_fill_done(fill_done), .smu_hold(hold), .mem_entries(mem_entries),
    .spill_cnt(spill_cnt), .fill_cnt(fill_cnt)
  );

  smu_dribble_ctl #(.CNT_W(4)) dut_sat (
    .pj_clk(pj_clk), .reset_l(reset_l), .dcu(bus2),
    .num_entries(num_entries), .hi_mark(hi_mark), .lo_mark(lo_mark),
    .dribble_en(dribble_en), .sc_bottom_wr(sc_bottom_wr), .sc_bottom_in(sc_bottom_in),
    .stat_clr(stat_clr), .sc_bottom(sc_bottom2), .smu_spill_done(spill_done2),
    .smu_fill_done(fill_done2), .smu_hold(hold2), .mem_entries(mem_entries2),
    .spill_cnt(spill_cnt2), .fill_cnt(fill_cnt2)
  );

  task automatic step(input int n);
    repeat (n) @(posedge pj_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_l = 1'b0; num_entries = '0; hi_mark = '0; lo_mark = '0;
    dribble_en = 1'b0; sc_bottom_wr = 1'b0; stat_clr = 1'b0; sc_bottom_in = '0;
    bus.dcu_ack = 1'b0;
    #12;
    chk("rst_req", 32'(bus.smu_req), 32'd0);
    chk("rst_addr", bus.smu_addr, 32'd0);
    chk("rst_bottom", sc_bottom, 32'd0);
    chk("rst_mem", 32'(mem_entries), 32'd0);
    chk("rst_hold", 32'(hold), 32'd0);
    reset_l = 1'b1;
    step(1);

    // SC_BOTTOM load, then fill blocked because nothing has been spilled
    sc_bottom_wr = 1'b1; sc_bottom_in = 32'h1000;
    step(1);
    sc_bottom_wr = 1'b0;
    chk("wr_bottom", sc_bottom, 32'h1000);
    hi_mark = 6'd48; lo_mark = 6'd8; num_entries = 6'd4; dribble_en = 1'b1;
    step(3);
    chk("fill_blocked", 32'(bus.smu_req), 32'd0);

    // Spill, ack two cycles after smu_req
    num_entries = 6'd50;
    step(1);
    chk("spill_req", 32'(bus.smu_req), 32'd1);
    chk("spill_we", 32'(bus.smu_we), 32'd1);
    chk("spill_addr", bus.smu_addr, 32'h1000);
    step(1);
    chk("spill_req_held", 32'(bus.smu_req), 32'd1);
    bus.dcu_ack = 1'b1; num_entries = 6'd4;
    step(1);
    bus.dcu_ack = 1'b0;
    chk("spill_req_drop", 32'(bus.smu_req), 32'd0);
    chk("spill_done", 32'(spill_done), 32'd1);
    chk("spill_bottom", sc_bottom, 32'hFFC);
    chk("spill_mem", 32'(mem_entries), 32'd1);
    chk("spill_cnt1", 32'(spill_cnt), 32'd1);
    step(1);
    chk("spill_done_pulse", 32'(spill_done), 32'd0);
    chk("cool_no_req", 32'(bus.smu_req), 32'd0);

    // Fill now allowed; earliest request three edges after the ack
    step(1);
    chk("fill_req", 32'(bus.smu_req), 32'd1);
    chk("fill_we", 32'(bus.smu_we), 32'd0);
    chk("fill_addr", bus.smu_addr, 32'h1000);
    bus.dcu_ack = 1'b1;
    step(1);
    bus.dcu_ack = 1'b0;
    chk("fill_done", 32'(fill_done), 32'd1);
    chk("fill_mem", 32'(mem_entries), 32'd0);
    chk("fill_bottom", sc_bottom, 32'h1000);
    chk("fill_cnt1", 32'(fill_cnt), 32'd1);
    step(3);
    chk("fill_stop", 32'(bus.smu_req), 32'd0);

    // lo_mark above hi_mark: spill wins; dribble_en drop does not abort
    lo_mark = 6'd60; hi_mark = 6'd10; num_entries = 6'd30;
    step(1);
    chk("prio_req", 32'(bus.smu_req), 32'd1);
    chk("prio_we", 32'(bus.smu_we), 32'd1);
    dribble_en = 1'b0;
    step(2);
    chk("dre_held", 32'(bus.smu_req), 32'd1);
    chk("dre_addr", bus.smu_addr, 32'h1000);
    bus.dcu_ack = 1'b1;
    step(1);
    bus.dcu_ack = 1'b0;
    chk("dre_bottom", sc_bottom, 32'hFFC);
    chk("dre_cnt", 32'(spill_cnt), 32'd2);
    step(4);
    chk("dre_no_new", 32'(bus.smu_req), 32'd0);

    // Spill and fill both eligible (mem_entries=1); spill wins
    dribble_en = 1'b1;
    step(1);
    chk("prio2_we", 32'(bus.smu_we), 32'd1);
    chk("prio2_addr", bus.smu_addr, 32'hFFC);

    // SC_BOTTOM write colliding with the spill ack
    bus.dcu_ack = 1'b1; sc_bottom_wr = 1'b1; sc_bottom_in = 32'h2003;
    dribble_en = 1'b0;
    step(1);
    bus.dcu_ack = 1'b0; sc_bottom_wr = 1'b0;
    chk("coll_bottom", sc_bottom, 32'h2000);
    chk("coll_mem", 32'(mem_entries), 32'd0);
    chk("coll_done", 32'(spill_done), 32'd1);
    chk("coll_cnt", 32'(spill_cnt), 32'd3);
    step(2);

    // stat_clr together with an ack
    lo_mark = 6'd8; hi_mark = 6'd48; num_entries = 6'd50; dribble_en = 1'b1;
    step(1);
    chk("clr_req", 32'(bus.smu_req), 32'd1);
    chk("clr_addr", bus.smu_addr, 32'h2000);
    bus.dcu_ack = 1'b1; stat_clr = 1'b1; num_entries = 6'd20;
    step(1);
    bus.dcu_ack = 1'b0; stat_clr = 1'b0;
    chk("clr_spill_cnt", 32'(spill_cnt), 32'd0);
    chk("clr_fill_cnt", 32'(fill_cnt), 32'd0);
    chk("clr_bottom", sc_bottom, 32'h1FFC);
    chk("clr_mem", 32'(mem_entries), 32'd1);
    step(2);

    // Overflow hold, independent of dribble_en
    dribble_en = 1'b0; num_entries = 6'd62;
    step(1);
    chk("hold_62", 32'(hold), 32'd1);
    num_entries = 6'd61;
    step(1);
    chk("hold_61", 32'(hold), 32'd0);

    // Saturation: continuous spills on the 4-bit-counter instance
    num_entries = 6'd50; dribble_en = 1'b1;
    step(60);
    chk("sat_spill_cnt", 32'(spill_cnt2), 32'hF);
    chk("sat_mem", 32'(mem_entries2), 32'hF);
    chk("main_addr_stable", bus.smu_addr, 32'h1FFC);

    // Asynchronous reset mid-request
    #3 reset_l = 1'b0;
    #1;
    chk("async_rst_req", 32'(bus.smu_req), 32'd0);
    chk("async_rst_bottom", sc_bottom, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
